// File: rtl/mskaes_32bits_key_ctrl_if.sv
// Handshake and control bundle between the masked AES key-schedule controller
// and its environment (start handshake, shared Sbox arbitration, AddRoundKey
// column stream and key datapath controls).
//   master : start requester / Sbox arbiter / AddRoundKey consumer side
//   slave  : key-schedule controller side
interface mskaes_32bits_key_ctrl_if;

    localparam int unsigned ROUND_W = 4;

    logic               in_valid;
    logic               in_ready;
    logic               sb_req;
    logic               sb_gnt;
    logic               rk_valid;
    logic               rk_ready;
    logic [ROUND_W-1:0] round_idx;
    logic               busy;
    logic               done;
    logic               init;
    logic               enable;
    logic               loop;
    logic               add_from_sb;
    logic               rcon_rst;
    logic               rcon_update;

    modport master (
        output in_valid,
        output sb_gnt,
        output rk_ready,
        input  in_ready,
        input  sb_req,
        input  rk_valid,
        input  round_idx,
        input  busy,
        input  done,
        input  init,
        input  enable,
        input  loop,
        input  add_from_sb,
        input  rcon_rst,
        input  rcon_update
    );

    modport slave (
        input  in_valid,
        input  sb_gnt,
        input  rk_ready,
        output in_ready,
        output sb_req,
        output rk_valid,
        output round_idx,
        output busy,
        output done,
        output init,
        output enable,
        output loop,
        output add_from_sb,
        output rcon_rst,
        output rcon_update
    );

endinterface

// File: rtl/mskaes_32bits_key_ctrl.sv
// Control FSM for a 32-bit-wide masked AES-128 key schedule.
// Streams each round key to AddRoundKey as four diagonal columns, then borrows
// the shared Sbox for the rotated key column and runs four update beats.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   kif.in_valid/ready  : start a key schedule from the shared key
//   kif.sb_req/gnt      : shared Sbox request / grant
//   kif.rk_valid/ready  : round-key column handshake towards AddRoundKey
//   kif.round_idx       : index of the round key being delivered
//   kif.busy, kif.done  : activity flag, one-cycle completion pulse
//   kif.init, enable, loop, add_from_sb, rcon_rst, rcon_update : key datapath controls
module mskaes_32bits_key_ctrl #(
    parameter int unsigned SB_LAT  = 4,
    parameter int unsigned NROUNDS = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    mskaes_32bits_key_ctrl_if.slave   kif
);

    localparam int unsigned BEAT_W  = 2;
    localparam int unsigned WAIT_W  = 4;
    localparam int unsigned ROUND_W = 4;

    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(3);
    localparam logic [WAIT_W-1:0]  WAIT_LOAD  = WAIT_W'(SB_LAT - 1);
    localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(NROUNDS);
    localparam bit                 SB_DIRECT  = (SB_LAT == 1);

    // Parameter legality: the wait and round counters are 4 bits wide.
    if (SB_LAT < 1 || SB_LAT > 15) begin : g_bad_sb_lat
        $error("SB_LAT must be in 1..15");
    end
    if (NROUNDS < 1 || NROUNDS > 15) begin : g_bad_nrounds
        $error("NROUNDS must be in 1..15");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_AK     = 3'd2,
        S_SBREQ  = 3'd3,
        S_SBWAIT = 3'd4,
        S_UPD    = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [BEAT_W-1:0]    beat_q,  beat_d;
    logic [WAIT_W-1:0]    wait_q,  wait_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    logic                 done_q,  done_d;

    logic                 init_c;
    logic                 enable_c;
    logic                 loop_c;
    logic                 add_from_sb_c;
    logic                 rcon_rst_c;
    logic                 rcon_update_c;
    logic                 sb_req_c;
    logic                 rk_valid_c;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin : p_regs
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            wait_q  <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    // Next-state and control decode.
    always_comb begin : p_next
        state_d       = state_q;
        beat_d        = beat_q;
        wait_d        = wait_q;
        round_d       = round_q;
        done_d        = 1'b0;
        init_c        = 1'b0;
        enable_c      = 1'b0;
        loop_c        = 1'b0;
        add_from_sb_c = 1'b0;
        rcon_rst_c    = 1'b0;
        rcon_update_c = 1'b0;
        sb_req_c      = 1'b0;
        rk_valid_c    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                beat_d = '0;
                if (kif.in_valid) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                init_c     = 1'b1;
                enable_c   = 1'b1;
                rcon_rst_c = 1'b1;
                round_d    = '0;
                beat_d     = '0;
                state_d    = S_AK;
            end

            // The key register rotates only on a consumed column, so a
            // stalled consumer leaves the round key untouched.
            S_AK: begin
                rk_valid_c = kif.rk_ready;
                enable_c   = kif.rk_ready;
                loop_c     = kif.rk_ready;
                if (kif.rk_ready) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_LAST) begin
                        if (round_q == ROUND_LAST) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_SBREQ;
                        end
                    end
                end
            end

            S_SBREQ: begin
                sb_req_c = 1'b1;
                if (kif.sb_gnt) begin
                    if (SB_DIRECT) begin
                        state_d = S_UPD;
                    end else begin
                        wait_d  = WAIT_LOAD;
                        state_d = S_SBWAIT;
                    end
                end
            end

            // Counter exits at 1 so the grant-to-UPD distance is SB_LAT.
            S_SBWAIT: begin
                if (wait_q <= WAIT_W'(1)) begin
                    wait_d  = '0;
                    state_d = S_UPD;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end

            S_UPD: begin
                enable_c      = 1'b1;
                add_from_sb_c = (beat_q == BEAT_W'(0));
                rcon_update_c = (beat_q == BEAT_LAST);
                beat_d        = beat_q + BEAT_W'(1);
                if (beat_q == BEAT_LAST) begin
                    round_d = (round_q >= ROUND_LAST) ? ROUND_LAST
                                                      : round_q + ROUND_W'(1);
                    state_d = S_AK;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign kif.in_ready    = (state_q == S_IDLE);
    assign kif.busy        = (state_q != S_IDLE);
    assign kif.done        = done_q;
    assign kif.round_idx   = round_q;
    assign kif.init        = init_c;
    assign kif.enable      = enable_c;
    assign kif.loop        = loop_c;
    assign kif.add_from_sb = add_from_sb_c;
    assign kif.rcon_rst    = rcon_rst_c;
    assign kif.rcon_update = rcon_update_c;
    assign kif.sb_req      = sb_req_c;
    assign kif.rk_valid    = rk_valid_c;

endmodule
